// File: rtl/phy_pkg.sv
// Shared definitions for the PCIe PHY link controller: FSM encoding,
// lane count and default training/fill symbols.
package phy_pkg;

   localparam int unsigned LANES = 4;
   localparam logic [7:0] COM_SYM_DEF  = 8'hBC;
   localparam logic [7:0] IDLE_SYM_DEF = 8'h7C;

   typedef enum logic [1:0] {
      RESET_S   = 2'd0,
      LINK_WAIT = 2'd1,
      ACTIVE    = 2'd2,
      RECOVER   = 2'd3
   } phy_state_e;

endpackage

// File: rtl/phy_lane_align.sv
// One lane's training tracker: counts consecutive COM symbols while waiting
// for the link and consecutive missing bytes once the link is up.
module phy_lane_align
   import phy_pkg::*;
#(
   parameter logic [7:0]  COM_SYM     = COM_SYM_DEF,
   parameter int unsigned ALIGN_COUNT = 4,
   parameter int unsigned LOSS_LIMIT  = 3
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_byte,
   input  logic        i_valid,
   input  phy_state_e  i_state,
   output logic        o_locked,
   output logic        o_lossHit
);

   localparam logic [3:0] ALIGN_MAX = 4'(ALIGN_COUNT);
   localparam logic [3:0] LOSS_MAX  = 4'(LOSS_LIMIT);

   logic [3:0] r_alignCnt;
   logic [3:0] r_lossCnt;

   // Align counter only moves in LINK_WAIT and is frozen in ACTIVE so data
   // bytes can never unlock a lane; everything else clears both counters.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_alignCnt <= '0;
         r_lossCnt  <= '0;
      end else begin
         case (i_state)
            LINK_WAIT: begin
               if (i_valid && (i_byte == COM_SYM)) begin
                  if (r_alignCnt != ALIGN_MAX)
                     r_alignCnt <= r_alignCnt + 4'd1;
               end else begin
                  r_alignCnt <= '0;
               end
               r_lossCnt <= '0;
            end
            ACTIVE: begin
               if (!i_valid) begin
                  if (r_lossCnt != 4'hF)
                     r_lossCnt <= r_lossCnt + 4'd1;
               end else begin
                  r_lossCnt <= '0;
               end
            end
            default: begin
               r_alignCnt <= '0;
               r_lossCnt  <= '0;
            end
         endcase
      end
   end

   assign o_locked = (r_alignCnt == ALIGN_MAX);

   // Flags the cycle whose edge will bring the loss count to the limit, so the
   // FSM leaves ACTIVE on that same edge.
   assign o_lossHit = (i_state == ACTIVE) && !i_valid && (r_lossCnt == (LOSS_MAX - 4'd1));

endmodule

// File: rtl/phy_link_ctrl.sv
// Link-training and lane-sequencing controller for the 4-lane PCIe PHY:
// declares the link up once all lanes align and drops it on lane loss.
module phy_link_ctrl
   import phy_pkg::*;
#(
   parameter logic [7:0]  COM_SYM     = COM_SYM_DEF,
   parameter logic [7:0]  IDLE_SYM    = IDLE_SYM_DEF,
   parameter int unsigned ALIGN_COUNT = 4,
   parameter int unsigned LOSS_LIMIT  = 3
) (
   input  logic       clk4f,
   input  logic       reset,
   input  logic [7:0] rx_byte0,
   input  logic [7:0] rx_byte1,
   input  logic [7:0] rx_byte2,
   input  logic [7:0] rx_byte3,
   input  logic [3:0] rx_valid,
   input  logic [3:0] tx_req,
   output logic       active,
   output logic       recir_en,
   output logic [3:0] lane_locked,
   output logic [3:0] tx_data_en,
   output logic [7:0] tx_sym,
   output logic [1:0] state,
   output logic [3:0] retrain_cnt
);

   phy_state_e r_state;
   phy_state_e w_nextState;
   logic [3:0] r_retrainCnt;
   logic [3:0] r_txDataEn;
   logic [3:0] w_locked;
   logic [3:0] w_lossHit;
   logic [7:0] w_rxByte [LANES];

   assign w_rxByte[0] = rx_byte0;
   assign w_rxByte[1] = rx_byte1;
   assign w_rxByte[2] = rx_byte2;
   assign w_rxByte[3] = rx_byte3;

   for (genvar g = 0; g < LANES; g++) begin : gLane
      phy_lane_align #(
         .COM_SYM     (COM_SYM),
         .ALIGN_COUNT (ALIGN_COUNT),
         .LOSS_LIMIT  (LOSS_LIMIT)
      ) uLane (
         .i_clk     (clk4f),
         .i_reset   (reset),
         .i_byte    (w_rxByte[g]),
         .i_valid   (rx_valid[g]),
         .i_state   (r_state),
         .o_locked  (w_locked[g]),
         .o_lossHit (w_lossHit[g])
      );
   end

   // Lock uses the registered lane flags, so a lane clearing in the same cycle
   // another lane locks simply holds the FSM in LINK_WAIT.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         RESET_S:   w_nextState = LINK_WAIT;
         LINK_WAIT: if (&w_locked) w_nextState = ACTIVE;
         ACTIVE:    if (|w_lossHit) w_nextState = RECOVER;
         RECOVER:   w_nextState = LINK_WAIT;
         default:   w_nextState = RESET_S;
      endcase
   end

   // Data enables look at the next state so they drop on the same edge that
   // leaves ACTIVE, and follow tx_req one edge late while the link is up.
   always_ff @(posedge clk4f or posedge reset) begin
      if (reset) begin
         r_state      <= RESET_S;
         r_retrainCnt <= '0;
         r_txDataEn   <= '0;
      end else begin
         r_state    <= w_nextState;
         r_txDataEn <= (w_nextState == ACTIVE) ? tx_req : 4'b0000;
         if ((r_state == ACTIVE) && (w_nextState == RECOVER) && (r_retrainCnt != 4'hF))
            r_retrainCnt <= r_retrainCnt + 4'd1;
      end
   end

   assign active      = (r_state == ACTIVE);
   assign recir_en    = ~active;
   assign tx_sym      = active ? IDLE_SYM : COM_SYM;
   assign lane_locked = w_locked;
   assign tx_data_en  = r_txDataEn;
   assign state       = r_state;
   assign retrain_cnt = r_retrainCnt;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed self-checking bench for phy_link_ctrl: training, broken runs,
// data enables, link loss, async reset and retrain counter saturation.
module tb_phy_link_ctrl;

   logic       clk4f;
   logic       reset;
   logic [7:0] rx_byte0, rx_byte1, rx_byte2, rx_byte3;
   logic [3:0] rx_valid;
   logic [3:0] tx_req;
   logic       active;
   logic       recir_en;
   logic [3:0] lane_locked;
   logic [3:0] tx_data_en;
   logic [7:0] tx_sym;
   logic [1:0] state;
   logic [3:0] retrain_cnt;

   int compareCount  = 0;
   int mismatchCount = 0;

   phy_link_ctrl dut (
      .clk4f       (clk4f),
      .reset       (reset),
      .rx_byte0    (rx_byte0),
      .rx_byte1    (rx_byte1),
      .rx_byte2    (rx_byte2),
      .rx_byte3    (rx_byte3),
      .rx_valid    (rx_valid),
      .tx_req      (tx_req),
      .active      (active),
      .recir_en    (recir_en),
      .lane_locked (lane_locked),
      .tx_data_en  (tx_data_en),
      .tx_sym      (tx_sym),
      .state       (state),
      .retrain_cnt (retrain_cnt)
   );

   initial clk4f = 1'b0;
   always #5 clk4f = ~clk4f;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one set of lane inputs, then waits one edge and settles 1ns past it.
   task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [3:0] valid, input logic [3:0] req);
      rx_byte0 = b0;
      rx_byte1 = b1;
      rx_byte2 = b2;
      rx_byte3 = b3;
      rx_valid = valid;
      tx_req   = req;
      @(posedge clk4f);
      #1;
   endtask

   task automatic applyCom(input logic [3:0] valid, input logic [3:0] req);
      applyStimulus(8'hBC, 8'hBC, 8'hBC, 8'hBC, valid, req);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      applyCom(4'h0, 4'h0);
      applyCom(4'h0, 4'h0);
      applyCom(4'h0, 4'h0);
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      rx_byte0 = 8'h00;
      rx_byte1 = 8'h00;
      rx_byte2 = 8'h00;
      rx_byte3 = 8'h00;
      rx_valid = 4'h0;
      tx_req   = 4'h0;

      // Lock on a clean COM run
      pulseReset();
      checkOutput("rst_state", 32'(state), 32'd0);
      checkOutput("rst_recir", 32'(recir_en), 32'd1);
      checkOutput("rst_txsym", 32'(tx_sym), 32'hBC);
      applyCom(4'hF, 4'h0);
      checkOutput("t1_linkwait", 32'(state), 32'd1);
      applyCom(4'hF, 4'h0);
      applyCom(4'hF, 4'h0);
      applyCom(4'hF, 4'h0);
      checkOutput("t1_lock_3com", 32'(lane_locked), 32'h0);
      applyCom(4'hF, 4'h0);
      checkOutput("t1_lock_4com", 32'(lane_locked), 32'hF);
      checkOutput("t1_not_active_yet", 32'(active), 32'd0);
      applyCom(4'hF, 4'h0);
      checkOutput("t1_active", 32'(active), 32'd1);
      checkOutput("t1_recir", 32'(recir_en), 32'd0);
      checkOutput("t1_txsym", 32'(tx_sym), 32'h7C);
      checkOutput("t1_state", 32'(state), 32'd2);

      // Broken run on lane 2, with tx_req held high through LINK_WAIT
      pulseReset();
      applyCom(4'hF, 4'hF);
      applyCom(4'hF, 4'hF);
      applyCom(4'hF, 4'hF);
      applyStimulus(8'hBC, 8'hBC, 8'hAA, 8'hBC, 4'hF, 4'hF);
      applyCom(4'hF, 4'hF);
      checkOutput("t2_lock_1011", 32'(lane_locked), 32'hB);
      checkOutput("t2_txen_wait", 32'(tx_data_en), 32'h0);
      applyCom(4'hF, 4'hF);
      applyCom(4'hF, 4'hF);
      checkOutput("t2_lock_still_1011", 32'(lane_locked), 32'hB);
      checkOutput("t2_state_wait", 32'(state), 32'd1);
      applyCom(4'hF, 4'hF);
      checkOutput("t2_lock_all", 32'(lane_locked), 32'hF);
      checkOutput("t2_active_delayed", 32'(active), 32'd0);
      applyCom(4'hF, 4'hF);
      checkOutput("t2_active", 32'(active), 32'd1);

      // Data enables follow tx_req one edge late
      checkOutput("t3_txen_entry", 32'(tx_data_en), 32'hF);
      applyCom(4'hF, 4'b0101);
      checkOutput("t3_txen_0101", 32'(tx_data_en), 32'h5);
      applyCom(4'hF, 4'b1111);
      checkOutput("t3_txen_1111", 32'(tx_data_en), 32'hF);

      // Short loss keeps the link, full loss drops it
      applyCom(4'b1101, 4'hF);
      applyCom(4'b1101, 4'hF);
      checkOutput("t4_short_loss", 32'(state), 32'd2);
      applyCom(4'hF, 4'hF);
      applyCom(4'b1101, 4'hF);
      applyCom(4'b1101, 4'hF);
      checkOutput("t4_loss2", 32'(active), 32'd1);
      applyCom(4'b1101, 4'hF);
      checkOutput("t4_recover", 32'(state), 32'd3);
      checkOutput("t4_active_low", 32'(active), 32'd0);
      checkOutput("t4_txen_low", 32'(tx_data_en), 32'h0);
      checkOutput("t4_retrain1", 32'(retrain_cnt), 32'd1);
      applyCom(4'hF, 4'hF);
      checkOutput("t4_back_wait", 32'(state), 32'd1);
      checkOutput("t4_lock_cleared", 32'(lane_locked), 32'h0);
      applyCom(4'hF, 4'hF);
      applyCom(4'hF, 4'hF);
      applyCom(4'hF, 4'hF);
      applyCom(4'hF, 4'hF);
      checkOutput("t4_relock", 32'(lane_locked), 32'hF);
      applyCom(4'hF, 4'hF);
      checkOutput("t4_reactive", 32'(active), 32'd1);
      checkOutput("t4_txen_again", 32'(tx_data_en), 32'hF);

      // Async reset between edges
      #3;
      reset = 1'b1;
      #1;
      checkOutput("t5_state", 32'(state), 32'd0);
      checkOutput("t5_active", 32'(active), 32'd0);
      checkOutput("t5_recir", 32'(recir_en), 32'd1);
      checkOutput("t5_lock", 32'(lane_locked), 32'h0);
      checkOutput("t5_txen", 32'(tx_data_en), 32'h0);
      checkOutput("t5_txsym", 32'(tx_sym), 32'hBC);
      checkOutput("t5_retrain", 32'(retrain_cnt), 32'd0);
      applyCom(4'h0, 4'h0);
      reset = 1'b0;

      // Retrain counter saturation over 17 drops
      for (int drop = 1; drop <= 17; drop++) begin
         for (int k = 0; k < 20 && state != 2'd2; k++)
            applyCom(4'hF, 4'h0);
         checkOutput("t6_reach_active", 32'(state), 32'd2);
         applyCom(4'b1110, 4'h0);
         applyCom(4'b1110, 4'h0);
         applyCom(4'b1110, 4'h0);
         checkOutput($sformatf("t6_retrain_drop%0d", drop), 32'(retrain_cnt),
                     (drop > 15) ? 32'd15 : 32'(drop));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
